riscv_wb_scheduler: RTL
=======================

// Module: riscv_wb_scheduler
// PURPOSE
//  Writeback stage directly upstream of the integer register file.
//  Collects results from three sources and drives the RF's two write ports (A, B):
//    EX (single-cycle ALU), LSU load responses, and a long-latency unit (mult/div).
//  Keeps a per-register scoreboard of pending long-latency and load destinations.
//  ID uses the scoreboard busy flags to stall on RAW/WAW hazards.
// PARAMETERS
//  ADDR_WIDTH  5   register address width; registers 0..2**ADDR_WIDTH-1, x0 hardwired zero
//  DATA_WIDTH  32  result/data width
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           asynchronous reset, active low
//  ex_valid_i     in   1           EX result valid this cycle (no backpressure)
//  ex_waddr_i     in   ADDR_WIDTH  EX destination register
//  ex_wdata_i     in   DATA_WIDTH  EX result
//  lsu_rvalid_i   in   1           load data valid (no backpressure, must be accepted)
//  lsu_waddr_i    in   ADDR_WIDTH  load destination register
//  lsu_rdata_i    in   DATA_WIDTH  load data
//  ll_valid_i     in   1           long-latency result valid
//  ll_ready_o     out  1           long-latency result accepted when valid&ready
//  ll_waddr_i     in   ADDR_WIDTH  long-latency destination register
//  ll_wdata_i     in   DATA_WIDTH  long-latency result
//  issue_valid_i  in   1           ID issues a load or long-latency op this cycle
//  issue_waddr_i  in   ADDR_WIDTH  destination of the issued op
//  raddr_a_i/b/c  in   ADDR_WIDTH  ID source addresses for hazard lookup
//  busy_a/b/c_o   out  1           scoreboard bit of raddr_x_i (combinational)
//  we_a_o         out  1           RF port A write enable (registered)
//  waddr_a_o      out  ADDR_WIDTH  RF port A address (registered)
//  wdata_a_o      out  DATA_WIDTH  RF port A data (registered)
//  we_b_o         out  1           RF port B write enable (registered)
//  waddr_b_o      out  ADDR_WIDTH  RF port B address (registered)
//  wdata_b_o      out  DATA_WIDTH  RF port B data (registered)
// BEHAVIOUR
//  Reset: all registered outputs are 0 and all scoreboard bits are 0.
//    ll_ready_o follows its combinational rule.
//  Port A: EX only.
//    Next edge: we_a_o <= ex_valid_i & (ex_waddr_i != 0).
//    waddr_a_o/wdata_a_o capture EX inputs. Latency is exactly 1 cycle.
//  Port B arbitration, fixed priority LSU > LL:
//    ll_ready_o = ~lsu_rvalid_i.
//    LSU valid -> port B loads LSU data next edge.
//    Else LL valid -> port B loads LL data next edge; LL handshake completes.
//    Else we_b_o <= 0.
//    Writes to register 0 are dropped: we_b_o = 0, but the LL handshake still completes.
//  When we_x_o = 0, waddr/wdata hold their previous values.
//  Same-address A/B writes in one cycle are legal; the RF gives port B priority.
//  Scoreboard bits 1..2**ADDR_WIDTH-1; bit 0 is constantly 0.
//    Set at the edge where issue_valid_i & issue_waddr_i != 0.
//    Cleared at the edge where we_b_o = 1 and waddr_b_o addresses it,
//      i.e. the same edge the RF commits the value. busy deasserts the cycle after commit.
//    Set and clear of the same bit on the same edge: set wins.
//  busy_x_o = scoreboard[raddr_x_i]; purely combinational, no same-cycle bypass.
//  EX results never touch the scoreboard; ID stalls EX-writers on busy destinations.
//  Reset mid-operation: outputs and scoreboard clear immediately (async).
//    In-flight LL handshakes are discarded.
// TESTING
//  1. ex_valid=1, waddr=5, data=0xDEADBEEF -> next cycle we_a=1, waddr_a=5, wdata_a=0xDEADBEEF.
//     With waddr=0 -> we_a=0.
//  2. issue x7, then lsu_rvalid with waddr=7, data=0x1234 three cycles later:
//     -> busy(raddr=7)=1 until the cycle after we_b=1, waddr_b=7, wdata_b=0x1234.
//  3. lsu_rvalid and ll_valid in the same cycle (x3, x4) -> ll_ready=0.
//     Port B writes x3, then x4 the next cycle; exactly one LL handshake.
//  4. Same edge: we_b commits x9 while issue_valid targets x9 -> busy stays 1.
//  5. ll_valid with waddr=0 -> ll_ready=1, we_b=0; scoreboard unchanged.
//  6. Scoreboard bits 2 and 6 set, port outputs non-zero; assert rst_n=0 mid-cycle
//     -> all busy and all we_x_o are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_wb_scheduler.sv
// Writeback scheduler in front of the integer register file. Port A carries EX results.
// Port B carries load/long-latency results, and a per-register scoreboard tracks pending destinations.
module riscv_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                  lsu_rvalid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
    input  logic                  ll_valid_i,
    output logic                  ll_ready_o,
    input  logic [ADDR_WIDTH-1:0] ll_waddr_i,
    input  logic [DATA_WIDTH-1:0] ll_wdata_i,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_waddr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  busy_c_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                  a_we_next;
    logic                  b_take;
    logic                  b_we_next;
    logic [ADDR_WIDTH-1:0] b_addr_next;
    logic [DATA_WIDTH-1:0] b_data_next;
    logic [NUM_REGS-1:0]   sb_q;
    logic [NUM_REGS-1:0]   sb_set;
    logic [NUM_REGS-1:0]   sb_clr;

    // Handshakes: EX and LSU are valid-only and always consumed. LL transfers on an edge
    // where ll_valid_i & ll_ready_o, and the LSU owns port B whenever it is valid.
    assign ll_ready_o = ~lsu_rvalid_i;

    assign a_we_next = ex_valid_i & (ex_waddr_i != '0);

    always_comb begin
        b_take      = lsu_rvalid_i | ll_valid_i;
        b_addr_next = lsu_rvalid_i ? lsu_waddr_i : ll_waddr_i;
        b_data_next = lsu_rvalid_i ? lsu_rdata_i : ll_wdata_i;
        b_we_next   = b_take & (b_addr_next != '0);
    end

    // Port A: address/data move only on a real write so the RF sees stable values otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
        end else begin
            we_a_o <= a_we_next;
            if (a_we_next) begin
                waddr_a_o <= ex_waddr_i;
                wdata_a_o <= ex_wdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else begin
            we_b_o <= b_we_next;
            if (b_we_next) begin
                waddr_b_o <= b_addr_next;
                wdata_b_o <= b_data_next;
            end
        end
    end

    // Clear tracks the registered port B write, i.e. the edge the RF commits it; set wins.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (issue_valid_i) sb_set[issue_waddr_i] = 1'b1;
        if (we_b_o)        sb_clr[waddr_b_o]     = 1'b1;
        sb_set[0] = 1'b0;
        sb_clr[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= (sb_q & ~sb_clr) | sb_set;
    end

    assign busy_a_o = sb_q[raddr_a_i];
    assign busy_b_o = sb_q[raddr_b_i];
    assign busy_c_o = sb_q[raddr_c_i];

endmodule
